// File: rtl/stopwatch_time_counter_if.sv
// Control/status bundle for the stopwatch time base.
// master drives the controls and target; slave is the counter side.
interface stopwatch_time_counter_if;
  logic        start_stop;
  logic        clear;
  logic        lap;
  logic [16:1] target;
  logic [16:1] time_out;
  logic [16:1] live_time;
  logic        running;
  logic        match;
  logic        rollover;

  modport master (
    output start_stop, clear, lap, target,
    input  time_out, live_time, running, match, rollover
  );

  modport slave (
    input  start_stop, clear, lap, target,
    output time_out, live_time, running, match, rollover
  );
endinterface

// File: rtl/stopwatch_time_counter.sv
// Stopwatch time base: 1 Hz prescaler, four-digit BCD MM:SS counter with
// start/stop, clear and lap freeze, plus target-match and rollover pulses.
module stopwatch_time_counter #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  stopwatch_time_counter_if.slave  bus
);
  localparam int              PW      = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0]   PMAX    = PW'(TICKS_PER_SEC - 1);
  // Per-digit wrap value, sec ones in slot 0 up to min tens in slot 3.
  localparam logic [3:0][3:0] DIG_MAX = {4'd5, 4'd9, 4'd5, 4'd9};

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t          state, state_d;
  logic [PW-1:0]   presc;
  logic [3:0][3:0] cnt, cnt_inc, snap;
  logic            hold;
  logic            match_q, roll_q;
  logic [4:0]      carry;
  logic            tick;

  assign tick     = (state == RUN) && (presc == PMAX);
  assign carry[0] = 1'b1;

  // BCD ripple increment: each digit steps only when all lower digits wrap.
  for (genvar i = 0; i < 4; i++) begin : g_dig
    logic wrap;
    assign wrap         = (cnt[i] == DIG_MAX[i]);
    assign carry[i+1]   = carry[i] & wrap;
    assign cnt_inc[i]   = !carry[i] ? cnt[i] : (wrap ? 4'd0 : cnt[i] + 4'd1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next state: clear dominates, start_stop toggles run/pause.
  always_comb begin
    state_d = state;
    if (bus.clear) begin
      state_d = IDLE;
    end else if (bus.start_stop) begin
      case (state)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Prescaler advances only while running; paused keeps the partial second.
  always_ff @(posedge clk) begin
    if (rst || bus.clear)  presc <= '0;
    else if (state == RUN) presc <= (presc == PMAX) ? '0 : presc + 1'b1;
  end

  // Live count plus registered match/rollover pulses on each tick.
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      cnt     <= '0;
      match_q <= 1'b0;
      roll_q  <= 1'b0;
    end else begin
      match_q <= tick && (cnt_inc == bus.target);
      roll_q  <= tick && carry[4];
      if (tick) cnt <= cnt_inc;
    end
  end

  // Lap freeze: capture takes the pre-increment count if a tick coincides.
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      hold <= 1'b0;
      snap <= '0;
    end else if (bus.lap) begin
      if (!hold) snap <= cnt;
      hold <= !hold;
    end
  end

  assign bus.live_time = cnt;
  assign bus.time_out  = hold ? snap : cnt;
  assign bus.running   = (state == RUN);
  assign bus.match     = match_q;
  assign bus.rollover  = roll_q;
endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Directed bench for the stopwatch time base at TICKS_PER_SEC = 4.
module tb_stopwatch_time_counter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  stopwatch_time_counter_if sw();

  stopwatch_time_counter #(.TICKS_PER_SEC(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sw)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ss();
    sw.start_stop = 1'b1; @(negedge clk); sw.start_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    sw.clear = 1'b1; @(negedge clk); sw.clear = 1'b0;
  endtask

  task automatic pulse_lap();
    sw.lap = 1'b1; @(negedge clk); sw.lap = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc(3); rst = 1'b0;
    n_vec++; if (sw.live_time !== 16'h0000) begin n_err++; $display("FAIL reset_live got %h want 0000", sw.live_time); end
    n_vec++; if (sw.time_out !== 16'h0000) begin n_err++; $display("FAIL reset_tout got %h want 0000", sw.time_out); end
    n_vec++; if ({sw.running, sw.match, sw.rollover} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b want 000", {sw.running, sw.match, sw.rollover}); end
  endtask

  task automatic test_run();
    sw.target = 16'h5000;
    pulse_ss();                 // after start edge E0
    n_vec++; if (sw.running !== 1'b1) begin n_err++; $display("FAIL run_running got %b want 1", sw.running); end
    cyc(3);                     // E3
    n_vec++; if (sw.live_time !== 16'h0000) begin n_err++; $display("FAIL run_e3 got %h want 0000", sw.live_time); end
    cyc(1);                     // E4: first tick
    n_vec++; if (sw.live_time !== 16'h0001) begin n_err++; $display("FAIL run_e4 got %h want 0001", sw.live_time); end
    n_vec++; if (sw.match !== 1'b0) begin n_err++; $display("FAIL run_nomatch got %b want 0", sw.match); end
    cyc(36);                    // E40: tenth tick
    n_vec++; if (sw.live_time !== 16'h0010) begin n_err++; $display("FAIL run_e40 got %h want 0010", sw.live_time); end
    pulse_clear();
    n_vec++; if ({sw.running, sw.live_time} !== {1'b0, 16'h0000}) begin n_err++; $display("FAIL run_clear got %b/%h want 0/0000", sw.running, sw.live_time); end
  endtask

  task automatic test_pause();
    pulse_ss();                 // E0
    cyc(5);                     // E5
    pulse_ss();                 // E6: prescaler 2, count 1, paused
    n_vec++; if ({sw.running, sw.live_time} !== {1'b0, 16'h0001}) begin n_err++; $display("FAIL pause_stop got %b/%h want 0/0001", sw.running, sw.live_time); end
    cyc(20);
    n_vec++; if (sw.live_time !== 16'h0001) begin n_err++; $display("FAIL pause_hold got %h want 0001", sw.live_time); end
    pulse_ss();                 // R0
    n_vec++; if ({sw.running, sw.live_time} !== {1'b1, 16'h0001}) begin n_err++; $display("FAIL pause_resume got %b/%h want 1/0001", sw.running, sw.live_time); end
    cyc(1);                     // R1
    n_vec++; if (sw.live_time !== 16'h0001) begin n_err++; $display("FAIL pause_r1 got %h want 0001", sw.live_time); end
    cyc(1);                     // R2: partial second completes
    n_vec++; if (sw.live_time !== 16'h0002) begin n_err++; $display("FAIL pause_r2 got %h want 0002", sw.live_time); end
    pulse_clear();
  endtask

  task automatic test_rst_mid();
    pulse_ss();                 // E0
    cyc(3);                     // E3: prescaler at 3
    rst = 1'b1; @(negedge clk); rst = 1'b0;   // E4 tick discarded
    n_vec++; if ({sw.running, sw.live_time, sw.rollover} !== {1'b0, 16'h0000, 1'b0}) begin n_err++; $display("FAIL rstmid got %b/%h/%b want 0/0000/0", sw.running, sw.live_time, sw.rollover); end
    pulse_ss();
    cyc(4);
    n_vec++; if (sw.live_time !== 16'h0001) begin n_err++; $display("FAIL rstmid_restart got %h want 0001", sw.live_time); end
    pulse_clear();
  endtask

  task automatic test_rollover();
    int spurious = 0;
    sw.target = 16'h0000;
    pulse_ss();                 // E0
    for (int i = 1; i <= 14396; i++) begin
      @(negedge clk);
      if (sw.match || sw.rollover) spurious++;
      if (i == 240) begin
        n_vec++; if (sw.live_time !== 16'h0100) begin n_err++; $display("FAIL roll_0100 got %h want 0100", sw.live_time); end
      end
      if (i == 2396) begin
        n_vec++; if (sw.live_time !== 16'h0959) begin n_err++; $display("FAIL roll_0959 got %h want 0959", sw.live_time); end
      end
      if (i == 2400) begin
        n_vec++; if (sw.live_time !== 16'h1000) begin n_err++; $display("FAIL roll_1000 got %h want 1000", sw.live_time); end
      end
    end
    n_vec++; if (spurious !== 0) begin n_err++; $display("FAIL roll_spurious got %0d want 0", spurious); end
    n_vec++; if (sw.live_time !== 16'h5959) begin n_err++; $display("FAIL roll_5959 got %h want 5959", sw.live_time); end
    cyc(4);                     // E14400
    n_vec++; if ({sw.live_time, sw.rollover, sw.match, sw.running} !== {16'h0000, 3'b111}) begin n_err++; $display("FAIL roll_wrap got %h/%b/%b/%b want 0000/1/1/1", sw.live_time, sw.rollover, sw.match, sw.running); end
    cyc(1);
    n_vec++; if ({sw.rollover, sw.match} !== 2'b00) begin n_err++; $display("FAIL roll_width got %b/%b want 0/0", sw.rollover, sw.match); end
    pulse_clear();
  endtask

  task automatic test_match();
    int hits = 0;
    int at   = -1;
    sw.target = 16'h0003;
    pulse_ss();                 // E0
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (sw.match) begin hits++; at = i; end
    end
    n_vec++; if (hits !== 1 || at !== 12) begin n_err++; $display("FAIL match_once got %0d hits at %0d want 1 at 12", hits, at); end
    pulse_ss();                 // paused at 0005
    n_vec++; if (sw.live_time !== 16'h0005) begin n_err++; $display("FAIL match_paused got %h want 0005", sw.live_time); end
    sw.target = 16'h0005;
    hits = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (sw.match) hits++; end
    n_vec++; if (hits !== 0) begin n_err++; $display("FAIL match_static got %0d want 0", hits); end
    pulse_clear();
    sw.target = 16'h000A;       // illegal digit, unreachable
    hits = 0;
    pulse_ss();
    for (int i = 1; i <= 44; i++) begin @(negedge clk); if (sw.match) hits++; end
    n_vec++; if (hits !== 0 || sw.live_time !== 16'h0011) begin n_err++; $display("FAIL match_illegal got %0d hits at %h want 0 at 0011", hits, sw.live_time); end
    pulse_clear();
  endtask

  task automatic test_lap();
    sw.target = 16'h5000;
    pulse_ss();                 // E0
    cyc(20);                    // E20: 0005
    n_vec++; if (sw.live_time !== 16'h0005) begin n_err++; $display("FAIL lap_pre got %h want 0005", sw.live_time); end
    pulse_lap();                // E21 capture
    cyc(11);                    // E32: 0008
    n_vec++; if ({sw.time_out, sw.live_time} !== {16'h0005, 16'h0008}) begin n_err++; $display("FAIL lap_frozen got %h/%h want 0005/0008", sw.time_out, sw.live_time); end
    pulse_lap();                // E33 release
    n_vec++; if (sw.time_out !== 16'h0008) begin n_err++; $display("FAIL lap_release got %h want 0008", sw.time_out); end
    cyc(2);                     // E35
    pulse_lap();                // E36 capture coincides with tick
    n_vec++; if ({sw.time_out, sw.live_time} !== {16'h0008, 16'h0009}) begin n_err++; $display("FAIL lap_tick got %h/%h want 0008/0009", sw.time_out, sw.live_time); end
  endtask

  task automatic test_simultaneous();
    // Still running with hold set from the lap test.
    sw.clear = 1'b1; sw.start_stop = 1'b1;
    @(negedge clk);
    sw.clear = 1'b0; sw.start_stop = 1'b0;
    n_vec++; if ({sw.running, sw.live_time, sw.time_out} !== {1'b0, 32'h0}) begin n_err++; $display("FAIL simul_clr_ss got %b/%h/%h want 0/0000/0000", sw.running, sw.live_time, sw.time_out); end
    sw.clear = 1'b1; sw.lap = 1'b1;
    @(negedge clk);
    sw.clear = 1'b0; sw.lap = 1'b0;
    pulse_ss();
    cyc(4);
    n_vec++; if ({sw.live_time, sw.time_out} !== {16'h0001, 16'h0001}) begin n_err++; $display("FAIL simul_hold got %h/%h want 0001/0001", sw.live_time, sw.time_out); end
    pulse_clear();
  endtask

  initial begin
    sw.start_stop = 1'b0;
    sw.clear      = 1'b0;
    sw.lap        = 1'b0;
    sw.target     = 16'h5000;
    test_reset();
    test_run();
    test_pause();
    test_rst_mid();
    test_rollover();
    test_match();
    test_lap();
    test_simultaneous();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/stopwatch_time_counter.md
# stopwatch_time_counter

Stopwatch time base: drives the 16-bit BCD MM:SS value consumed by the 16-bit equality comparator and the display path. It divides the system clock to 1 Hz, steps a four-digit BCD minutes:seconds count under start/stop, clear and lap control, and flags when the live count reaches a programmed target. It is the producer of the `a` operand the equality comparator checks against the user target.

## Interface
- `TICKS_PER_SEC`, default 50_000_000: `clk` cycles per counted second; legal range 2 or more.
- `clk`  in  1: system clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset; overrides every other input.
- `start_stop`  in  1: single-cycle pulse; toggles between running and paused.
- `clear`  in  1: single-cycle pulse; zeroes the count, prescaler and lap hold, and stops the counter.
- `lap`  in  1: single-cycle pulse; toggles the display freeze.
- `target`  in  [16:1]: BCD MM:SS target. `[16:13]` is min tens, `[12:9]` min ones, `[8:5]` sec tens, `[4:1]` sec ones.
- `time_out`  out  [16:1]: displayed BCD MM:SS. Live count, or the lap snapshot while lap hold is active.
- `live_time`  out  [16:1]: live BCD count, never frozen. This is the comparator operand.
- `running`  out  1: high in RUN.
- `match`  out  1: one-cycle pulse when the live count steps onto `target`.
- `rollover`  out  1: one-cycle pulse on the step from 59:59 to 00:00.

## Operation
- **States:**
  - IDLE: stopped, count 00:00.
  - RUN: counting.
  - PAUSE: stopped, count nonzero or prescaler nonzero.
- **Transitions:**
  - IDLE to RUN on `start_stop`.
  - RUN to PAUSE on `start_stop`.
  - PAUSE to RUN on `start_stop`.
  - Any state to IDLE on `clear` or `rst`.
- **Input priority:** `rst` > `clear` > `start_stop`; `lap` is independent of `start_stop`.
  - `clear` and `start_stop` in the same cycle: `clear` wins; the result is IDLE, not running.
  - `lap` in the same cycle as `clear`: `clear` wins; lap hold ends up 0.
- **Prescaler:** counts 0 to `TICKS_PER_SEC`-1 only in RUN. It holds its value in PAUSE, so a resume keeps the partial second. It is zeroed by `clear` and `rst`.
- **Tick:** in RUN, when the prescaler equals `TICKS_PER_SEC`-1, the prescaler wraps to 0 and the count increments on the same edge.
- **BCD increment:**
  - sec ones wraps 9 to 0 and carries into sec tens.
  - sec tens wraps 5 to 0 and carries into min ones.
  - min ones wraps 9 to 0 and carries into min tens.
  - min tens wraps 5 to 0.
  - Every digit of `live_time` stays a legal BCD digit at all times.
- **Rollover:** 59:59 steps to 00:00 and `rollover` pulses; counting continues.
- **Lap:**
  - `lap` with hold=0 captures `live_time` into the snapshot and sets hold=1.
  - `lap` with hold=1 clears hold, so `time_out` returns to live.
  - If a tick lands on the same edge as the lap capture, the snapshot takes the pre-increment value.
  - Lap works in every state.
- **Match:**
  - `match` is registered and goes high on the same edge that `live_time` takes a value equal to `target` through a tick.
  - There is no match from reset, clear, or a `target` change while the count is static.
  - A target holding an illegal BCD digit can never match.

## Timing
- **Reset values:**
  - `time_out` = 0x0000 and `live_time` = 0x0000.
  - `running`, `match` and `rollover` = 0.
  - Lap hold = 0; prescaler = 0.
- **Latency:**
  - `start_stop` sampled at edge N: `running` changes at edge N.
  - The first tick after a start from IDLE comes `TICKS_PER_SEC` edges later.
- **Pulse widths:** `match` and `rollover` are exactly one cycle; both assert together when `target` = 0x0000 and the count rolls over.
- **Reset mid-operation:** `rst` or `clear` in RUN zeroes everything at that edge. A tick due on the same edge is discarded.
- **Outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
Every scenario uses `TICKS_PER_SEC`=4.
- **Reset then run:** `rst`, then `start_stop` → `running`=1, `live_time` 0x0001 four edges later, 0x0010 after 40 edges.
- **Pause preserves partial second:** run 6 cycles, `start_stop`, wait 20, `start_stop` → next increment 2 cycles after resume, value 0x0002.
- **Rollover and wrap match:** preload by running to 59:59 (0x5959) with `target`=0x0000 → next tick gives `live_time`=0x0000, `rollover`=1 and `match`=1 for one cycle, `running` stays 1.
- **Target match:** `target`=0x0003, run → `match` pulses once, on the edge `live_time` becomes 0x0003; a later `target` write of the current value gives no pulse.
- **Lap freeze:** at 0x0005 pulse `lap` → `time_out` holds 0x0005 while `live_time` reaches 0x0008; second `lap` → `time_out`=0x0008 next cycle.
- **Simultaneous events:** `clear` and `start_stop` in the same cycle during RUN → IDLE, both outputs 0x0000, `running`=0, lap hold cleared.
